// File: rtl/mcpu_mem_atom_scratchpad.sv
// Atom-interface scratchpad responder: 2^DEPTH_LOG2 x 256-bit window at BASE_ATOM, fixed-latency in-order reads.
// Optional zero-fill after reset is enabled by defining SPM_ZERO_INIT_EN.
module mcpu_mem_atom_scratchpad #(
   parameter logic [26:0] BASE_ATOM  = 27'h0,
   parameter int          DEPTH_LOG2 = 6,
   parameter int          LATENCY    = 2
) (
   input  logic         arb2spm_clk,
   input  logic         arb2spm_rst_n,
   input  logic         arb2spm_valid,
   input  logic [2:0]   arb2spm_opcode,
   input  logic [26:0]  arb2spm_addr,
   input  logic [255:0] arb2spm_wdata,
   input  logic [31:0]  arb2spm_wbe,
   output logic [255:0] arb2spm_rdata,
   output logic         arb2spm_rvalid,
   output logic         arb2spm_stall,
   output logic         spm_init_done,
   output logic         spm_oob_err,
   input  logic         spm_oob_clr
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   // Opcode encodings shared with MCPU_MEM_ltc.vh.
   localparam logic [2:0] LTC_OPC_READ  = 3'b000;
   localparam logic [2:0] LTC_OPC_WRITE = 3'b001;

   logic [255:0]          mem [DEPTH];
   logic [255:0]          merged;
   logic [255:0]          rd_q;
   logic                  accept;
   logic                  hit;
   logic                  is_read;
   logic                  is_write;
   logic [DEPTH_LOG2-1:0] index;
   logic                  req_v;
   logic                  req_hit;
   logic [LATENCY-1:0]    pipe_v;
   logic [255:0]          pipe_d [LATENCY];

   assign accept   = arb2spm_valid & ~arb2spm_stall;
   assign hit      = (arb2spm_addr[26:DEPTH_LOG2] == BASE_ATOM[26:DEPTH_LOG2]);
   assign index    = arb2spm_addr[DEPTH_LOG2-1:0];
   assign is_read  = accept & (arb2spm_opcode == LTC_OPC_READ);
   assign is_write = accept & hit & (arb2spm_opcode == LTC_OPC_WRITE);

`ifdef SPM_ZERO_INIT_EN
   logic [DEPTH_LOG2-1:0] init_cnt;

   // Zero-fill sequencer; stall doubles as the "fill in progress" flag.
   always_ff @(posedge arb2spm_clk or negedge arb2spm_rst_n) begin
      if (!arb2spm_rst_n) begin
         init_cnt      <= '0;
         arb2spm_stall <= 1'b1;
         spm_init_done <= 1'b0;
      end else if (arb2spm_stall) begin
         init_cnt <= init_cnt + 1'b1;
         if (init_cnt == {DEPTH_LOG2{1'b1}}) begin
            arb2spm_stall <= 1'b0;
            spm_init_done <= 1'b1;
         end else begin
            arb2spm_stall <= 1'b1;
            spm_init_done <= 1'b0;
         end
      end else begin
         init_cnt      <= init_cnt;
         arb2spm_stall <= 1'b0;
         spm_init_done <= 1'b1;
      end
   end
`else
   assign arb2spm_stall = 1'b0;
   assign spm_init_done = 1'b1;
`endif

   // Byte-enable merge of write data into the currently addressed atom.
   always_comb begin
      merged = '0;
      for (int i = 0; i < 32; i++) begin
         merged[8*i +: 8] = arb2spm_wbe[i] ? arb2spm_wdata[8*i +: 8] : mem[index][8*i +: 8];
      end
   end

   // RAM array: zero-fill, merged writes and the read port captured at accept.
   always_ff @(posedge arb2spm_clk) begin
`ifdef SPM_ZERO_INIT_EN
      if (arb2spm_stall) begin
         mem[init_cnt] <= '0;
      end
`endif
      if (is_write) begin
         mem[index] <= merged;
      end
      rd_q <= mem[index];
   end

   // Request tracking and sticky out-of-window flag; a new violation beats clear.
   always_ff @(posedge arb2spm_clk or negedge arb2spm_rst_n) begin
      if (!arb2spm_rst_n) begin
         req_v       <= 1'b0;
         req_hit     <= 1'b0;
         spm_oob_err <= 1'b0;
      end else begin
         req_v   <= is_read;
         req_hit <= hit;
         if (accept && !hit) begin
            spm_oob_err <= 1'b1;
         end else if (spm_oob_clr) begin
            spm_oob_err <= 1'b0;
         end else begin
            spm_oob_err <= spm_oob_err;
         end
      end
   end

   // Response pipe; data is zero whenever its valid bit is clear.
   always_ff @(posedge arb2spm_clk or negedge arb2spm_rst_n) begin
      if (!arb2spm_rst_n) begin
         pipe_v <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            pipe_d[i] <= '0;
         end
      end else begin
         pipe_v[0] <= req_v;
         pipe_d[0] <= (req_v && req_hit) ? rd_q : 256'h0;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
         end
      end
   end

   assign arb2spm_rvalid = pipe_v[LATENCY-1];
   assign arb2spm_rdata  = pipe_d[LATENCY-1];

endmodule

// File: tb/tb_mcpu_mem_atom_scratchpad.sv
// Directed bench for mcpu_mem_atom_scratchpad (window at atom 0x40, 64 atoms, latency 2).
// Expectations follow SPM_ZERO_INIT_EN when the bench is built with it defined.
module tb_mcpu_mem_atom_scratchpad;

   localparam logic [26:0] B      = 27'h40;
   localparam logic [2:0]  OPC_RD = 3'b000;
   localparam logic [2:0]  OPC_WR = 3'b001;
   localparam logic [2:0]  OPC_NP = 3'b111;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         valid;
   logic [2:0]   opcode;
   logic [26:0]  addr;
   logic [255:0] wdata;
   logic [31:0]  wbe;
   logic [255:0] rdata;
   logic         rvalid;
   logic         stall;
   logic         init_done;
   logic         oob_err;
   logic         oob_clr;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [255:0] d1;
   logic [255:0] d2;
   logic [255:0] d3;

   mcpu_mem_atom_scratchpad #(.BASE_ATOM(B), .DEPTH_LOG2(6), .LATENCY(2)) dut (
      .arb2spm_clk    (clk),
      .arb2spm_rst_n  (rst_n),
      .arb2spm_valid  (valid),
      .arb2spm_opcode (opcode),
      .arb2spm_addr   (addr),
      .arb2spm_wdata  (wdata),
      .arb2spm_wbe    (wbe),
      .arb2spm_rdata  (rdata),
      .arb2spm_rvalid (rvalid),
      .arb2spm_stall  (stall),
      .spm_init_done  (init_done),
      .spm_oob_err    (oob_err),
      .spm_oob_clr    (oob_clr)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic [26:0] a, input logic [255:0] d, input logic [31:0] be);
      valid  = 1'b1;
      opcode = op;
      addr   = a;
      wdata  = d;
      wbe    = be;
   endtask

   task automatic do_read(input logic [26:0] a, input logic [255:0] exp, input string nm);
      drive(OPC_RD, a, 256'h0, 32'h0);
      tick;
      valid = 1'b0;
      n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL %s_early1: rvalid=%0b want 0", nm, rvalid); end
      tick;
      n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL %s_early2: rvalid=%0b want 0", nm, rvalid); end
      tick;
      n_cmp++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL %s_rvalid: rvalid=%0b want 1", nm, rvalid); end
      n_cmp++; if (rdata !== exp) begin n_fail++; $display("FAIL %s_rdata: got %h want %h", nm, rdata, exp); end
      tick;
      n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL %s_late: rvalid=%0b want 0", nm, rvalid); end
      n_cmp++; if (rdata !== 256'h0) begin n_fail++; $display("FAIL %s_idle_rdata: got %h want 0", nm, rdata); end
   endtask

   task automatic do_write(input logic [26:0] a, input logic [255:0] d, input logic [31:0] be);
      drive(OPC_WR, a, d, be);
      tick;
      valid = 1'b0;
      n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL write_no_rvalid: rvalid=%0b want 0", rvalid); end
   endtask

   task automatic test_reset;
      repeat (3) tick;
      n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %0b want 0", rvalid); end
      n_cmp++; if (rdata !== 256'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", rdata); end
      n_cmp++; if (oob_err !== 1'b0) begin n_fail++; $display("FAIL rst_oob: got %0b want 0", oob_err); end
`ifdef SPM_ZERO_INIT_EN
      n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_stall: got %0b want 1", stall); end
      n_cmp++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL rst_init_done: got %0b want 0", init_done); end
`else
      n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %0b want 0", stall); end
      n_cmp++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL rst_init_done: got %0b want 1", init_done); end
`endif
   endtask

   task automatic test_init;
`ifdef SPM_ZERO_INIT_EN
      int cnt;
      int guard;
      cnt   = 0;
      guard = 0;
      drive(OPC_RD, B + 27'd5, 256'h0, 32'h0);
      rst_n = 1'b1;
      while (stall === 1'b1 && guard < 200) begin
         cnt++;
         n_cmp++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL init_done_early: got %0b want 0 at cycle %0d", init_done, cnt); end
         n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL init_rvalid: got %0b want 0 at cycle %0d", rvalid, cnt); end
         tick;
         guard++;
      end
      n_cmp++; if (cnt != 64) begin n_fail++; $display("FAIL init_stall_cycles: got %0d want 64", cnt); end
      n_cmp++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL init_done: got %0b want 1", init_done); end
      tick;
      valid = 1'b0;
      n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL held_early1: rvalid=%0b want 0", rvalid); end
      tick;
      n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL held_early2: rvalid=%0b want 0", rvalid); end
      tick;
      n_cmp++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL held_rvalid: rvalid=%0b want 1", rvalid); end
      n_cmp++; if (rdata !== 256'h0) begin n_fail++; $display("FAIL held_rdata: got %h want 0", rdata); end
      for (int i = 0; i < 6; i++) begin
         tick;
         n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL held_extra_rvalid: rvalid=%0b want 0 (cycle %0d)", rvalid, i); end
      end
`else
      rst_n = 1'b1;
      tick;
      n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL noinit_stall: got %0b want 0", stall); end
      n_cmp++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL noinit_done: got %0b want 1", init_done); end
      do_write(B + 27'd5, 256'h0, 32'hFFFF_FFFF);
      do_read(B + 27'd5, 256'h0, "zero_read");
`endif
   endtask

   task automatic test_merge;
      drive(OPC_WR, B + 27'd3, {8{32'hDEADBEEF}}, 32'hFFFF_FFFF);
      tick;
      drive(OPC_WR, B + 27'd3, 256'h0, 32'h0000_000F);
      tick;
      n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL merge_wr_rvalid: rvalid=%0b want 0", rvalid); end
      do_read(B + 27'd3, d3, "merge");
      do_write(B + 27'd1, d1, 32'hFFFF_FFFF);
      do_write(B + 27'd2, {32{8'h22}}, 32'hFFFF_FFFF);
      do_write(B + 27'd2, {32{8'hFF}}, 32'h8000_0001);
      do_read(B + 27'd2, d2, "partial");
   endtask

   task automatic test_back_to_back;
      drive(OPC_RD, B + 27'd1, 256'h0, 32'h0);
      tick;
      drive(OPC_RD, B + 27'd2, 256'h0, 32'h0);
      tick;
      n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_early: rvalid=%0b want 0", rvalid); end
      drive(OPC_RD, B + 27'd3, 256'h0, 32'h0);
      tick;
      valid = 1'b0;
      n_cmp++; if (rvalid !== 1'b1 || rdata !== d1) begin n_fail++; $display("FAIL b2b_first: rvalid=%0b rdata=%h want 1/%h", rvalid, rdata, d1); end
      tick;
      n_cmp++; if (rvalid !== 1'b1 || rdata !== d2) begin n_fail++; $display("FAIL b2b_second: rvalid=%0b rdata=%h want 1/%h", rvalid, rdata, d2); end
      tick;
      n_cmp++; if (rvalid !== 1'b1 || rdata !== d3) begin n_fail++; $display("FAIL b2b_third: rvalid=%0b rdata=%h want 1/%h", rvalid, rdata, d3); end
      tick;
      n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_after: rvalid=%0b want 0", rvalid); end
   endtask

   task automatic test_oob;
      n_cmp++; if (oob_err !== 1'b0) begin n_fail++; $display("FAIL oob_initial: got %0b want 0", oob_err); end
      do_read(B + 27'd64, 256'h0, "oob_above");
      n_cmp++; if (oob_err !== 1'b1) begin n_fail++; $display("FAIL oob_set_above: got %0b want 1", oob_err); end
      oob_clr = 1'b1;
      tick;
      oob_clr = 1'b0;
      n_cmp++; if (oob_err !== 1'b0) begin n_fail++; $display("FAIL oob_clr1: got %0b want 0", oob_err); end
      do_read(B - 27'd1, 256'h0, "oob_below");
      n_cmp++; if (oob_err !== 1'b1) begin n_fail++; $display("FAIL oob_set_below: got %0b want 1", oob_err); end
      drive(OPC_WR, B + 27'd67, {32{8'hFF}}, 32'hFFFF_FFFF);
      oob_clr = 1'b1;
      tick;
      valid   = 1'b0;
      oob_clr = 1'b0;
      n_cmp++; if (oob_err !== 1'b1) begin n_fail++; $display("FAIL oob_set_wins: got %0b want 1", oob_err); end
      tick;
      n_cmp++; if (oob_err !== 1'b1) begin n_fail++; $display("FAIL oob_sticky: got %0b want 1", oob_err); end
      oob_clr = 1'b1;
      tick;
      oob_clr = 1'b0;
      n_cmp++; if (oob_err !== 1'b0) begin n_fail++; $display("FAIL oob_clr2: got %0b want 0", oob_err); end
      drive(OPC_NP, B + 27'd3, 256'h0, 32'hFFFF_FFFF);
      tick;
      valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL nop_rvalid: rvalid=%0b want 0 (cycle %0d)", rvalid, i); end
         tick;
      end
      do_read(B + 27'd3, d3, "after_drop");
      n_cmp++; if (oob_err !== 1'b0) begin n_fail++; $display("FAIL nop_oob: got %0b want 0", oob_err); end
   endtask

   task automatic test_reset_inflight;
      int guard;
      do_read(B + 27'd64, 256'h0, "pre_rst_oob");
      drive(OPC_RD, B + 27'd1, 256'h0, 32'h0);
      tick;
      drive(OPC_RD, B + 27'd2, 256'h0, 32'h0);
      tick;
      valid = 1'b0;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rst2_rvalid: got %0b want 0", rvalid); end
      n_cmp++; if (rdata !== 256'h0) begin n_fail++; $display("FAIL rst2_rdata: got %h want 0", rdata); end
      n_cmp++; if (oob_err !== 1'b0) begin n_fail++; $display("FAIL rst2_oob: got %0b want 0", oob_err); end
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick;
         n_cmp++; if (rvalid !== 1'b0 || rdata !== 256'h0) begin n_fail++; $display("FAIL rst2_ghost: rvalid=%0b rdata=%h want 0/0 (cycle %0d)", rvalid, rdata, i); end
      end
      guard = 0;
      while (init_done !== 1'b1 && guard < 100) begin
         tick;
         guard++;
      end
      n_cmp++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL rst2_init_timeout: init_done=%0b want 1", init_done); end
`ifdef SPM_ZERO_INIT_EN
      do_read(B + 27'd1, 256'h0, "rst2_refilled");
`else
      do_read(B + 27'd1, d1, "rst2_retained");
`endif
   endtask

   initial begin
      rst_n   = 1'b0;
      valid   = 1'b0;
      opcode  = OPC_RD;
      addr    = 27'h0;
      wdata   = 256'h0;
      wbe     = 32'h0;
      oob_clr = 1'b0;
      d1 = {8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, {24{8'hA1}}};
      d2 = {8'hFF, {30{8'h22}}, 8'hFF};
      d3 = {{7{32'hDEADBEEF}}, 32'h0};
      test_reset;
      test_init;
      test_merge;
      test_back_to_back;
      test_oob;
      test_reset_inflight;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
